// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT
    } i2c_tgt_state_e;

    localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

    // Bit counter has to reach 8 (byte complete), so 4 bits.
    localparam int I2C_BIT_CNT_W = 4;

    // General call is never acknowledged, even if the own address were 0.
    function automatic logic i2c_addr_match(input logic [6:0] rx_addr,
                                            input logic [6:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != I2C_GENERAL_CALL);
    endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// I2C pad-side signals. The target uses the slave view; the board/bench drives
// the pad levels through the master view.
interface i2c_target_regs_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;
    logic sda_oe;

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_o,
        output sda_oe
    );

    modport master (
        output scl_i,
        output sda_i,
        input  sda_o,
        input  sda_oe
    );
endinterface

// File: rtl/i2c_target_filter.sv
// Two-flop synchronizer plus stability filter for one asynchronous pad level.
// The filtered output follows the synchronized input only after it has held a
// new level for FILTER_LEN consecutive clocks; it powers up high (idle bus).
module i2c_target_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic out_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // Metastability guard on the raw pad level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    // Down-counter reloads whenever the input agrees with the output; a new
    // level is accepted when the counter reaches terminal count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b1;
            cnt_q  <= CNT_LOAD;
        end else if (sync2_q == filt_q) begin
            cnt_q  <= CNT_LOAD;
        end else if (cnt_q == '0) begin
            filt_q <= sync2_q;
            cnt_q  <= CNT_LOAD;
        end else begin
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    assign out_o = filt_q;

endmodule

// File: rtl/i2c_target_regs.sv
// Open-drain I2C target with a small byte-wide register file and an
// auto-incrementing pointer. Clocked fast enough to oversample SCL.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | bus free or after reset; waits for START
// ST_ADDR     | shifting in address + R/W
// ST_ADDR_ACK | own address seen; drive ACK for one SCL low-high-low
// ST_PTR      | shifting in pointer byte
// ST_PTR_ACK  | ACK pointer byte
// ST_WDATA    | shifting in data byte
// ST_WACK     | ACK data byte; register written on ACK assertion
// ST_RDATA    | shifting reg[ptr] out MSB first
// ST_RACK     | SDA released; sample controller ACK/NACK
// ST_WAIT     | not addressed / read ended; ignore bus until START or STOP
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int          NUM_REGS   = 16,
    parameter int          FILTER_LEN = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    i2c_target_regs_if.slave            bus,
    output logic                        wr_valid_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
    output logic [7:0]                  wr_data_o,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr_i,
    output logic [7:0]                  dbg_data_o,
    output logic                        busy_o
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [I2C_BIT_CNT_W-1:0] BIT_ONE  = I2C_BIT_CNT_W'(1);
    localparam logic [I2C_BIT_CNT_W-1:0] BIT_LAST = I2C_BIT_CNT_W'(7);
    localparam logic [I2C_BIT_CNT_W-1:0] BIT_DONE = I2C_BIT_CNT_W'(8);

    logic scl_f, sda_f;
    logic scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    i2c_tgt_state_e            state_q, state_d;
    logic [I2C_BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic [AW-1:0]             ptr_q, ptr_d;
    logic                      sda_oe_q, sda_oe_d;
    logic                      reg_we;
    logic [7:0]                byte_in;
    logic [7:0]                rd_byte;

    logic [7:0]                regs_q [NUM_REGS];
    logic                      wr_valid_q;
    logic [AW-1:0]             wr_addr_q;
    logic [7:0]                wr_data_q;
    logic [7:0]                dbg_data_q;

    i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (bus.scl_i),
        .out_o  (scl_f)
    );

    i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (bus.sda_i),
        .out_o  (sda_f)
    );

    // Previous filtered levels for edge and bus-condition detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign scl_rise  =  scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f &  scl_prev_q;
    assign start_det =  scl_f &  scl_prev_q &  sda_prev_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_prev_q & ~sda_prev_q &  sda_f;

    assign byte_in = {shift_q[6:0], sda_f};
    assign rd_byte = regs_q[ptr_q];

    // FSM state, shifter, bit counter, pointer and SDA drive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Next state. Inside the ACK states sda_oe_q tells the 8th SCL fall
    // (assert ACK) apart from the 9th (release and move on).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        reg_we    = 1'b0;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR) begin
                                state_d = i2c_addr_match(byte_in[7:1], ADDR) ? ST_ADDR_ACK : ST_WAIT;
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = byte_in[AW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                state_d = ST_WACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (shift_q[0]) begin
                            // Read: first data bit goes out on this same fall.
                            state_d   = ST_RDATA;
                            sda_oe_d  = ~rd_byte[7];
                            shift_d   = {rd_byte[6:0], 1'b0};
                            bit_cnt_d = BIT_ONE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WDATA;
                        end
                    end
                end
                ST_WACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            reg_we   = 1'b1;
                            ptr_d    = ptr_q + AW'(1);
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == '0) begin
                            sda_oe_d  = ~rd_byte[7];
                            shift_d   = {rd_byte[6:0], 1'b0};
                            bit_cnt_d = BIT_ONE;
                        end else if (bit_cnt_q == BIT_DONE) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + AW'(1);
                            bit_cnt_d = '0;
                            state_d   = ST_RACK;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        state_d = sda_f ? ST_WAIT : ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file; a write lands on the same clock the ACK is asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[ptr_q] <= shift_q;
        end
    end

    // Write notification, one clock per written byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= reg_we;
            if (reg_we) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= shift_q;
            end
        end
    end

    // Debug read port; a same-cycle write shows up one clock later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dbg_data_q <= '0;
        else         dbg_data_q <= regs_q[dbg_addr_i];
    end

    assign bus.sda_o  = 1'b0;
    assign bus.sda_oe = sda_oe_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign dbg_data_o = dbg_data_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: the bench acts as I2C controller, keeps its own
// picture of the register file and pointer, and compares bus read data, ACKs,
// write notifications and the debug port against it.
module tb_i2c_target_regs;

    localparam int         NUM_REGS   = 16;
    localparam int         FILTER_LEN = 3;
    localparam logic [6:0] OWN        = 7'h50;
    localparam int         Q          = 8;   // clocks per SCL quarter

    logic       clk_sys = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       scl_m   = 1'b1;
    logic       sda_m   = 1'b1;
    logic [3:0] dbg_addr = '0;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] dbg_data;
    logic       busy;

    i2c_target_regs_if bus_if ();

    assign bus_if.scl_i = scl_m;
    assign bus_if.sda_i = sda_m & ~bus_if.sda_oe;

    i2c_target_regs #(
        .ADDR       (OWN),
        .NUM_REGS   (NUM_REGS),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk_i      (clk_sys),
        .rst_ni     (rst_ni),
        .bus        (bus_if),
        .wr_valid_o (wr_valid),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .busy_o     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: register contents and pointer as the bus protocol defines them.
    logic [7:0]  m_regs [NUM_REGS];
    int          m_ptr = 0;
    logic [12:0] exp_wr [$];
    logic [12:0] act_wr [$];
    logic [7:0]  tx_data [8];
    bit          oe_seen   = 1'b0;
    bit          busy_seen = 1'b0;
    logic        oe_prev   = 1'b0;
    int          oe_bad    = 0;

    // Bus monitor: write strobes (with ACK level), SDA drive activity, busy,
    // and any SDA drive change while SCL is high.
    always @(negedge clk_sys) begin
        if (wr_valid) act_wr.push_back({bus_if.sda_oe, wr_addr, wr_data});
        if (bus_if.sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (rst_ni && scl_m && (bus_if.sda_oe != oe_prev)) oe_bad++;
        oe_prev = bus_if.sda_oe;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b1; clks(Q);
    endtask

    task automatic bus_bit(input logic b, output logic line);
        sda_m = b;    clks(Q);
        scl_m = 1'b1; clks(Q);
        line = bus_if.sda_i;
        clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic tx_byte(input logic [7:0] b, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], l);
        bus_bit(1'b1, l);
        ack = ~l;
    endtask

    task automatic rx_byte(input logic ack, output logic [7:0] b);
        logic       l;
        logic [7:0] v;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, l);
            v[i] = l;
        end
        bus_bit(~ack, l);
        b = v;
    endtask

    task automatic check_wr();
        int n;
        check_val("wr_count", act_wr.size(), exp_wr.size());
        n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check_val("wr_event", act_wr[i], exp_wr[i]);
        act_wr.delete();
        exp_wr.delete();
    endtask

    task automatic chk_dbg(input int idx);
        dbg_addr = 4'(idx);
        clks(1);
        check_val("dbg_data", dbg_data, m_regs[idx]);
    endtask

    task automatic wr_txn(input logic [7:0] ptr_b, input int n, input bit stop);
        logic ack;
        bus_start();
        tx_byte({OWN, 1'b0}, ack);
        check_val("wr_addr_ack", ack, 1'b1);
        tx_byte(ptr_b, ack);
        check_val("ptr_ack", ack, 1'b1);
        m_ptr = ptr_b % NUM_REGS;
        for (int i = 0; i < n; i++) begin
            tx_byte(tx_data[i], ack);
            check_val("data_ack", ack, 1'b1);
            m_regs[m_ptr] = tx_data[i];
            exp_wr.push_back({1'b1, 4'(m_ptr), tx_data[i]});
            m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        if (stop) bus_stop();
        check_wr();
    endtask

    task automatic rd_txn(input int n);
        logic       ack;
        logic [7:0] b;
        bus_start();
        tx_byte({OWN, 1'b1}, ack);
        check_val("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            rx_byte(i != n - 1, b);
            check_val("rd_data", b, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        check_val("rd_release", bus_if.sda_oe, 1'b0);
        bus_stop();
        check_wr();
    endtask

    task automatic bad_txn(input logic [6:0] a);
        logic ack;
        oe_seen = 1'b0;
        bus_start();
        tx_byte({a, 1'($urandom)}, ack);
        check_val("bad_addr_nack", ack, 1'b0);
        tx_byte(8'($urandom), ack);
        check_val("bad_data_nack", ack, 1'b0);
        bus_stop();
        check_val("bad_oe_quiet", oe_seen, 1'b0);
        check_wr();
    endtask

    initial begin
        logic       ack;
        logic [6:0] a;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;

        // Reset values, sampled while reset is held.
        clks(3);
        check_val("rst_sda_oe",   bus_if.sda_oe, 1'b0);
        check_val("rst_sda_o",    bus_if.sda_o,  1'b0);
        check_val("rst_wr_valid", wr_valid, 1'b0);
        check_val("rst_wr_addr",  wr_addr,  4'h0);
        check_val("rst_wr_data",  wr_data,  8'h00);
        check_val("rst_dbg_data", dbg_data, 8'h00);
        check_val("rst_busy",     busy,     1'b0);
        rst_ni = 1'b1;
        clks(5);

        // Pointer write followed by two data bytes.
        tx_data[0] = 8'h11; tx_data[1] = 8'h22;
        wr_txn(8'h03, 2, 1'b1);
        chk_dbg(4);
        chk_dbg(3);

        // Pointer write, repeated START, read two bytes (ACK then NACK).
        wr_txn(8'h03, 0, 1'b0);
        rd_txn(2);

        // Foreign address and general call.
        bad_txn(7'h51);
        bad_txn(7'h00);

        // Pointer wrap and pointer modulo.
        tx_data[0] = 8'h55; tx_data[1] = 8'h66;
        wr_txn(8'h0F, 2, 1'b1);
        chk_dbg(15);
        chk_dbg(0);
        wr_txn(8'h13, 0, 1'b1);
        rd_txn(1);

        // Glitch rejection on SDA with SCL high.
        busy_seen = 1'b0;
        sda_m = 1'b0; clks(1); sda_m = 1'b1; clks(20);
        check_val("glitch1_no_start", busy_seen, 1'b0);
        busy_seen = 1'b0;
        sda_m = 1'b0; clks(FILTER_LEN - 1); sda_m = 1'b1; clks(20);
        check_val("glitch2_no_start", busy_seen, 1'b0);
        busy_seen = 1'b0;
        sda_m = 1'b0; clks(FILTER_LEN); sda_m = 1'b1; clks(20);
        check_val("pulse3_start", busy_seen, 1'b1);
        check_val("pulse3_idle", busy, 1'b0);

        // Randomized mix of writes, reads from current pointer, foreign addresses.
        repeat (10) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
                    wr_txn(8'($urandom), int'($urandom_range(0, 3)), 1'b1);
                end
                1: rd_txn(int'($urandom_range(1, 3)));
                default: begin
                    a = 7'($urandom);
                    if (a == OWN) a = a ^ 7'h01;
                    bad_txn(a);
                end
            endcase
        end

        // Reset while the target is driving a 0 data bit.
        tx_data[0] = 8'h3C;
        wr_txn(8'h05, 1, 1'b1);
        wr_txn(8'h05, 0, 1'b1);
        bus_start();
        tx_byte({OWN, 1'b1}, ack);
        check_val("mid_rd_ack", ack, 1'b1);
        check_val("mid_rd_drive", bus_if.sda_oe, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_val("rst_async_oe", bus_if.sda_oe, 1'b0);
        check_val("rst_async_busy", busy, 1'b0);
        sda_m = 1'b1;
        clks(3);
        rst_ni = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        act_wr.delete();
        exp_wr.delete();
        for (int i = 0; i < NUM_REGS; i++) chk_dbg(i);
        scl_m = 1'b1;
        clks(Q);
        tx_data[0] = 8'hA5; tx_data[1] = 8'h5A;
        wr_txn(8'h07, 2, 1'b1);
        wr_txn(8'h07, 0, 1'b1);
        rd_txn(2);

        // Final register file sweep and SDA timing discipline.
        for (int i = 0; i < NUM_REGS; i++) chk_dbg(i);
        check_val("oe_change_scl_high", oe_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
